mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between the instruction-fetch (IF) and data-memory (DM, MEM stage) requesters.
- Drives the select of the N-bit 2:1 address/control multiplexer in front of the memory.
- Sequences each access over a variable-latency req/ready handshake and returns per-requester completion pulses and stalls to the pipeline control.
- DM has priority, bounded by a starvation limit that guarantees IF forward progress.

---
 rtl/mem_port_arbiter.sv | 83 ++++++++
 tb/tb_mem_port_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for the shared single-port unified memory
module mem_port_arbiter #(
  parameter int MAX_DM_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic dm_we,
  input  logic mem_ready,
  output logic addr_sel,
  output logic mem_req,
  output logic mem_we,
  output logic if_done,
  output logic dm_done,
  output logic if_stall,
  output logic dm_stall
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_DM_RUN);

  state_t     state, state_nxt;
  logic [3:0] dm_run, dm_run_nxt;
  logic       we_q, we_nxt;
  logic       busy_if, busy_dm;
  logic       arb, if_want, dm_want, dm_win;

  assign busy_if = (state == BUSY_IF);
  assign busy_dm = (state == BUSY_DM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dm_run <= 4'd0;
      we_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      dm_run <= dm_run_nxt;
      we_q   <= we_nxt;
    end
  end

  // The unused encoding behaves like IDLE so the FSM can never lock up.
  always_comb begin
    state_nxt  = state;
    dm_run_nxt = dm_run;
    we_nxt     = we_q;
    arb        = (~busy_if & ~busy_dm) | mem_ready;
    if_want    = if_req & ~busy_if;
    dm_want    = dm_req & ~busy_dm;
    dm_win     = dm_want & (~if_want | (dm_run < RUN_MAX));
    if (arb) begin
      if (dm_win) begin
        state_nxt = BUSY_DM;
        we_nxt    = dm_we;
        if (if_want)
          dm_run_nxt = (dm_run < RUN_MAX) ? dm_run + 4'd1 : dm_run;
        else
          dm_run_nxt = 4'd0;
      end else if (if_want) begin
        state_nxt  = BUSY_IF;
        dm_run_nxt = 4'd0;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  assign addr_sel = busy_dm;
  assign mem_req  = busy_if | busy_dm;
  assign mem_we   = busy_dm & we_q;
  assign if_done  = busy_if & mem_ready;
  assign dm_done  = busy_dm & mem_ready;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst, if_req, dm_req, dm_we, mem_ready;
  logic addr_sel, mem_req, mem_we, if_done, dm_done, if_stall, dm_stall;

  mem_port_arbiter #(.MAX_DM_RUN(MAX)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .dm_req(dm_req), .dm_we(dm_we),
    .mem_ready(mem_ready), .addr_sel(addr_sel), .mem_req(mem_req),
    .mem_we(mem_we), .if_done(if_done), .dm_done(dm_done),
    .if_stall(if_stall), .dm_stall(dm_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ir, dr, we, mr;
    logic [6:0] exp;   // {addr_sel, mem_req, mem_we, if_done, dm_done, if_stall, dm_stall}
  } vec_t;

  vec_t vecs[24];
  int checks = 0;
  int errors = 0;

  // Reference model: who owns the memory, how many DM grants IF has sat through
  int owner;   // 0 none, 1 IF, 2 DM
  int run;
  bit wel;
  bit if_on, dm_on;

  function automatic logic [6:0] outs();
    return {addr_sel, mem_req, mem_we, if_done, dm_done, if_stall, dm_stall};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ir, input logic dr, input logic we, input logic mr);
    rst = r; if_req = ir; dm_req = dr; dm_we = we; mem_ready = mr;
  endtask

  function automatic logic [6:0] model_out();
    logic ifd, dmd;
    ifd = (owner == 1) && mem_ready;
    dmd = (owner == 2) && mem_ready;
    return {owner == 2, owner != 0, (owner == 2) && wel, ifd, dmd,
            if_req && !ifd, dm_req && !dmd};
  endfunction

  task automatic model_step();
    bit wi, wd;
    if (rst) begin
      owner = 0; run = 0;
    end else if (owner == 0 || mem_ready) begin
      wi = if_req && owner != 1;
      wd = dm_req && owner != 2;
      if (wd && (!wi || run < MAX)) begin
        owner = 2;
        wel   = dm_we;
        run   = wi ? ((run + 1 > MAX) ? MAX : run + 1) : 0;
      end else if (wi) begin
        owner = 1; run = 0;
      end else begin
        owner = 0;
      end
    end
  endtask

  initial begin
    int first_run, cur_run, max_run, nif;
    bit seen_if;
    logic [6:0] e;

    // rst ir dr we mr   addr mreq we ifd dmd ifs dms
    vecs[0]  = '{0,0,0,0,1, 7'b000_00_00};  // spurious ready in IDLE
    vecs[1]  = '{0,1,0,0,0, 7'b000_00_10};  // IF read, 3-cycle memory
    vecs[2]  = '{0,1,0,0,0, 7'b010_00_10};
    vecs[3]  = '{0,1,0,0,0, 7'b010_00_10};
    vecs[4]  = '{0,1,0,0,1, 7'b010_10_00};
    vecs[5]  = '{0,0,0,0,0, 7'b000_00_00};
    vecs[6]  = '{0,1,1,1,1, 7'b000_00_11};  // conflict: DM then IF back-to-back
    vecs[7]  = '{0,1,1,1,1, 7'b111_01_10};
    vecs[8]  = '{0,1,0,0,1, 7'b010_10_00};
    vecs[9]  = '{0,0,0,0,1, 7'b000_00_00};
    vecs[10] = '{0,1,0,0,0, 7'b000_00_10};  // IF withdraws mid-access
    vecs[11] = '{0,0,0,0,0, 7'b010_00_00};
    vecs[12] = '{0,0,0,0,1, 7'b010_10_00};
    vecs[13] = '{0,0,0,0,0, 7'b000_00_00};
    vecs[14] = '{0,0,1,1,0, 7'b000_00_01};  // reset mid DM write
    vecs[15] = '{0,0,1,1,0, 7'b111_00_01};
    vecs[16] = '{1,0,1,1,0, 7'b111_00_01};
    vecs[17] = '{0,0,0,0,1, 7'b000_00_00};
    vecs[18] = '{0,0,1,0,0, 7'b000_00_01};  // dm_we latched at grant
    vecs[19] = '{0,0,1,1,0, 7'b110_00_01};
    vecs[20] = '{0,0,1,1,1, 7'b110_01_00};
    vecs[21] = '{0,0,1,1,0, 7'b000_00_01};  // reissue passes through IDLE
    vecs[22] = '{0,0,0,0,1, 7'b111_01_00};
    vecs[23] = '{0,0,0,0,0, 7'b000_00_00};

    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", outs(), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rst, vecs[i].ir, vecs[i].dr, vecs[i].we, vecs[i].mr);
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
      @(posedge clk); #1;
    end

    // Both requesters held high with a 1-cycle memory
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 1, 1, 0, 1);
    first_run = 0; cur_run = 0; max_run = 0; nif = 0; seen_if = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (dm_done) cur_run++;
      if (if_done) begin
        if (!seen_if) first_run = cur_run;
        seen_if = 1;
        if (cur_run > max_run) max_run = cur_run;
        cur_run = 0;
        nif++;
      end
      @(posedge clk); #1;
    end
    chk("starve_first_dm_wins", first_run >= 1, 1);
    chk("starve_first_bound", first_run <= MAX, 1);
    chk("starve_max_run", max_run <= MAX, 1);
    chk("starve_if_progress", nif >= 5, 1);

    // Randomized traffic against the reference model
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    owner = 0; run = 0; wel = 0; if_on = 0; dm_on = 0;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!if_on) if_on = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 49) == 0) if_on = 0;
      if (!dm_on) begin
        dm_on = ($urandom_range(0, 2) == 0);
        dm_we = $urandom_range(0, 1);
      end else if ($urandom_range(0, 49) == 0) begin
        dm_on = 0;
      end else if ($urandom_range(0, 9) == 0) begin
        dm_we = ~dm_we;
      end
      if_req = if_on;
      dm_req = dm_on;
      mem_ready = $urandom_range(0, 1);
      @(negedge clk);
      e = model_out();
      chk($sformatf("rand%0d", c), outs(), e);
      if (e[3]) if_on = $urandom_range(0, 1);
      if (e[2]) dm_on = $urandom_range(0, 1);
      model_step();
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
